dispram_write_arb: RTL and testbench



---
 rtl/dispram_write_arb.sv | 148 ++++++++++++++
 tb/tb_dispram_write_arb.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dispram_write_arb.sv
// Display RAM write-port arbiter: round-robin between a host pixel port and a
// rectangular-run fill engine, with optional blanking-only write eligibility.
module dispram_write_arb #(
  parameter int AW         = 19,
  parameter int DW         = 12,
  parameter int FB_SIZE    = 307200,
  parameter int BLANK_ONLY = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          blank,
  input  logic          h_valid,
  output logic          h_ready,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_data,
  input  logic          fill_start,
  input  logic          fill_abort,
  input  logic [AW-1:0] fill_base,
  input  logic [AW-1:0] fill_len,
  input  logic [DW-1:0] fill_colour,
  output logic          fill_busy,
  output logic          fill_done,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          err_oob
);

  typedef enum logic {IDLE, RUN} fill_state_e;

  // One extra bit so FB_SIZE == 2**AW still compares correctly.
  localparam logic [AW:0] FbLimit = (AW+1)'(FB_SIZE);

  fill_state_e   state_q, state_d;
  logic [AW-1:0] fillAddr_q, fillAddr_d;
  logic [AW-1:0] fillCnt_q, fillCnt_d;
  logic [DW-1:0] fillColour_q, fillColour_d;
  logic          favourHost_q, favourHost_d;
  logic          ramWe_q, ramWe_d;
  logic [AW-1:0] ramAddr_q, ramAddr_d;
  logic [DW-1:0] ramDin_q, ramDin_d;
  logic          fillDone_q, fillDone_d;
  logic          errOob_q, errOob_d;

  logic elig, fillRun, hostGrant, fillGrant, hostOob, fillOob;

  always_comb begin
    elig      = (BLANK_ONLY != 0) ? blank : 1'b1;
    fillRun   = (state_q == RUN);
    h_ready   = !rst && elig && (!fillRun || favourHost_q);
    hostGrant = h_valid && h_ready;
    fillGrant = !rst && fillRun && elig && !hostGrant;
    hostOob   = {1'b0, h_addr} >= FbLimit;
    fillOob   = {1'b0, fillAddr_q} >= FbLimit;

    state_d      = state_q;
    fillAddr_d   = fillAddr_q;
    fillCnt_d    = fillCnt_q;
    fillColour_d = fillColour_q;
    favourHost_d = favourHost_q;
    ramWe_d      = 1'b0;
    ramAddr_d    = ramAddr_q;
    ramDin_d     = ramDin_q;
    fillDone_d   = 1'b0;
    errOob_d     = 1'b0;

    if (hostGrant) begin
      favourHost_d = 1'b0;
      if (hostOob) begin
        errOob_d = 1'b1;
      end else begin
        ramWe_d   = 1'b1;
        ramAddr_d = h_addr;
        ramDin_d  = h_data;
      end
    end

    if (fillGrant) begin
      favourHost_d = 1'b1;
      if (fillOob) begin
        // Run truncated at the end of the frame buffer.
        errOob_d   = 1'b1;
        fillDone_d = !fill_abort;
        state_d    = IDLE;
      end else begin
        ramWe_d    = 1'b1;
        ramAddr_d  = fillAddr_q;
        ramDin_d   = fillColour_q;
        fillAddr_d = fillAddr_q + AW'(1);
        fillCnt_d  = fillCnt_q - AW'(1);
        if (fillCnt_q == AW'(1)) begin
          state_d    = IDLE;
          fillDone_d = !fill_abort;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (fill_start && !fill_abort) begin
          fillAddr_d   = fill_base;
          fillCnt_d    = fill_len;
          fillColour_d = fill_colour;
          if (fill_len == '0) fillDone_d = 1'b1;
          else                state_d    = RUN;
        end
      end
      RUN: begin
        if (fill_abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fillAddr_q   <= '0;
      fillCnt_q    <= '0;
      fillColour_q <= '0;
      favourHost_q <= 1'b1;
      ramWe_q      <= 1'b0;
      ramAddr_q    <= '0;
      ramDin_q     <= '0;
      fillDone_q   <= 1'b0;
      errOob_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fillAddr_q   <= fillAddr_d;
      fillCnt_q    <= fillCnt_d;
      fillColour_q <= fillColour_d;
      favourHost_q <= favourHost_d;
      ramWe_q      <= ramWe_d;
      ramAddr_q    <= ramAddr_d;
      ramDin_q     <= ramDin_d;
      fillDone_q   <= fillDone_d;
      errOob_q     <= errOob_d;
    end
  end

  assign fill_busy = (state_q == RUN);
  assign fill_done = fillDone_q;
  assign ram_we    = ramWe_q;
  assign ram_addr  = ramAddr_q;
  assign ram_din   = ramDin_q;
  assign err_oob   = errOob_q;

endmodule

// File: tb/tb_dispram_write_arb.sv
// Directed bench for dispram_write_arb: instance A always eligible, instance B
// writes only during blanking; both share stimulus.
module tb_dispram_write_arb;

  logic        clk = 1'b0;
  logic        rst, blank, hValid, fillStart, fillAbort;
  logic [18:0] hAddr, fillBase, fillLen;
  logic [11:0] hData, fillColour;

  logic        hReadyA, fillBusyA, fillDoneA, ramWeA, errOobA;
  logic [18:0] ramAddrA;
  logic [11:0] ramDinA;
  logic        hReadyB, fillBusyB, fillDoneB, ramWeB, errOobB;
  logic [18:0] ramAddrB;
  logic [11:0] ramDinB;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dispram_write_arb #(.BLANK_ONLY(0)) dutA (
    .clk(clk), .rst(rst), .blank(blank), .h_valid(hValid), .h_ready(hReadyA),
    .h_addr(hAddr), .h_data(hData), .fill_start(fillStart), .fill_abort(fillAbort),
    .fill_base(fillBase), .fill_len(fillLen), .fill_colour(fillColour),
    .fill_busy(fillBusyA), .fill_done(fillDoneA), .ram_we(ramWeA),
    .ram_addr(ramAddrA), .ram_din(ramDinA), .err_oob(errOobA));

  dispram_write_arb #(.BLANK_ONLY(1)) dutB (
    .clk(clk), .rst(rst), .blank(blank), .h_valid(hValid), .h_ready(hReadyB),
    .h_addr(hAddr), .h_data(hData), .fill_start(fillStart), .fill_abort(fillAbort),
    .fill_base(fillBase), .fill_len(fillLen), .fill_colour(fillColour),
    .fill_busy(fillBusyB), .fill_done(fillDoneB), .ram_we(ramWeB),
    .ram_addr(ramAddrB), .ram_din(ramDinB), .err_oob(errOobB));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic startFill(input int base, input int len, input int colour);
    fillStart  = 1'b1;
    fillBase   = 19'(base);
    fillLen    = 19'(len);
    fillColour = 12'(colour);
    nextCycle();
    fillStart  = 1'b0;
  endtask

  initial begin
    logic [8:0] blankPat;
    int expAddr;

    rst = 1'b1; blank = 1'b0; hValid = 1'b0; fillStart = 1'b0; fillAbort = 1'b0;
    hAddr = '0; hData = '0; fillBase = '0; fillLen = '0; fillColour = '0;
    nextCycle();
    nextCycle();

    // Reset state
    checkOutput("rst_we",     32'(ramWeA), 0);
    checkOutput("rst_addr",   32'(ramAddrA), 0);
    checkOutput("rst_din",    32'(ramDinA), 0);
    checkOutput("rst_busy",   32'(fillBusyA), 0);
    checkOutput("rst_done",   32'(fillDoneA), 0);
    checkOutput("rst_oob",    32'(errOobA), 0);
    checkOutput("rst_hready", 32'(hReadyA), 0);
    rst = 1'b0;
    #1 checkOutput("idle_hready", 32'(hReadyA), 1);
    nextCycle();
    checkOutput("postrst_we", 32'(ramWeA), 0);

    // Host-only write
    hValid = 1'b1; hAddr = 19'd5; hData = 12'hF00;
    #1 checkOutput("host_hready", 32'(hReadyA), 1);
    nextCycle();
    hValid = 1'b0;
    checkOutput("host_we",   32'(ramWeA), 1);
    checkOutput("host_addr", 32'(ramAddrA), 5);
    checkOutput("host_din",  32'(ramDinA), 'hF00);
    nextCycle();
    checkOutput("host_we_off",  32'(ramWeA), 0);
    checkOutput("host_addr_hold", 32'(ramAddrA), 5);

    // Plain fill of four pixels
    startFill(10, 4, 'h0F0);
    checkOutput("fill_busy", 32'(fillBusyA), 1);
    checkOutput("fill_we0",  32'(ramWeA), 0);
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      checkOutput("fill_we",   32'(ramWeA), 1);
      checkOutput("fill_addr", 32'(ramAddrA), 32'(10 + i));
      checkOutput("fill_din",  32'(ramDinA), 'h0F0);
      checkOutput("fill_done", 32'(fillDoneA), (i == 3) ? 1 : 0);
    end
    checkOutput("fill_busy_end", 32'(fillBusyA), 0);
    nextCycle();
    checkOutput("fill_we_after",   32'(ramWeA), 0);
    checkOutput("fill_done_after", 32'(fillDoneA), 0);

    // Round-robin against a continuously requesting host, host first after reset
    rst = 1'b1; nextCycle(); rst = 1'b0; nextCycle();
    startFill(100, 8, 'h00F);
    hValid = 1'b1; hAddr = 19'd200; hData = 12'hAAA;
    #1 checkOutput("rr_hready", 32'(hReadyA), 1);
    for (int k = 1; k <= 16; k++) begin
      nextCycle();
      checkOutput("rr_we", 32'(ramWeA), 1);
      if (k % 2 == 1) begin
        checkOutput("rr_host_addr", 32'(ramAddrA), 200);
        checkOutput("rr_host_din",  32'(ramDinA), 'hAAA);
      end else begin
        checkOutput("rr_fill_addr", 32'(ramAddrA), 32'(100 + k / 2 - 1));
        checkOutput("rr_fill_din",  32'(ramDinA), 'h00F);
      end
      checkOutput("rr_done", 32'(fillDoneA), (k == 16) ? 1 : 0);
    end
    hValid = 1'b0;
    checkOutput("rr_busy_end", 32'(fillBusyA), 0);
    nextCycle();

    // Fill truncated at the end of the frame buffer, then out-of-range host write
    startFill(307198, 5, 'h123);
    nextCycle();
    checkOutput("oob_we0",   32'(ramWeA), 1);
    checkOutput("oob_addr0", 32'(ramAddrA), 307198);
    nextCycle();
    checkOutput("oob_we1",   32'(ramWeA), 1);
    checkOutput("oob_addr1", 32'(ramAddrA), 307199);
    nextCycle();
    checkOutput("oob_we2",   32'(ramWeA), 0);
    checkOutput("oob_err",   32'(errOobA), 1);
    checkOutput("oob_done",  32'(fillDoneA), 1);
    checkOutput("oob_busy",  32'(fillBusyA), 0);
    checkOutput("oob_hold",  32'(ramAddrA), 307199);
    nextCycle();
    checkOutput("oob_err_off", 32'(errOobA), 0);
    hValid = 1'b1; hAddr = 19'd307200; hData = 12'h555;
    #1 checkOutput("hoob_hready", 32'(hReadyA), 1);
    nextCycle();
    hValid = 1'b0;
    checkOutput("hoob_we",  32'(ramWeA), 0);
    checkOutput("hoob_err", 32'(errOobA), 1);
    checkOutput("hoob_din", 32'(ramDinA), 'h123);
    nextCycle();
    checkOutput("hoob_err_off", 32'(errOobA), 0);

    // Zero-length fill completes at once
    startFill(7, 0, 'h111);
    checkOutput("len0_done", 32'(fillDoneA), 1);
    checkOutput("len0_busy", 32'(fillBusyA), 0);
    checkOutput("len0_we",   32'(ramWeA), 0);
    nextCycle();
    checkOutput("len0_done_off", 32'(fillDoneA), 0);

    // Start and abort together: abort wins
    fillAbort = 1'b1;
    startFill(30, 3, 'h222);
    fillAbort = 1'b0;
    checkOutput("sa_busy", 32'(fillBusyA), 0);
    checkOutput("sa_done", 32'(fillDoneA), 0);
    nextCycle();
    checkOutput("sa_we", 32'(ramWeA), 0);

    // Abort after two fill writes; the abort-cycle grant still lands
    startFill(50, 10, 'h0AB);
    nextCycle();
    checkOutput("ab_addr0", 32'(ramAddrA), 50);
    nextCycle();
    checkOutput("ab_addr1", 32'(ramAddrA), 51);
    fillAbort = 1'b1;
    nextCycle();
    fillAbort = 1'b0;
    checkOutput("ab_we",   32'(ramWeA), 1);
    checkOutput("ab_addr2", 32'(ramAddrA), 52);
    checkOutput("ab_busy", 32'(fillBusyA), 0);
    checkOutput("ab_done", 32'(fillDoneA), 0);
    nextCycle();
    checkOutput("ab_we_off",   32'(ramWeA), 0);
    checkOutput("ab_done_off", 32'(fillDoneA), 0);

    // Reset in the middle of a fill
    startFill(60, 10, 'h777);
    nextCycle();
    checkOutput("mr_addr", 32'(ramAddrA), 60);
    rst = 1'b1;
    #1 checkOutput("mr_hready", 32'(hReadyA), 0);
    nextCycle();
    checkOutput("mr_we",   32'(ramWeA), 0);
    checkOutput("mr_addr0", 32'(ramAddrA), 0);
    checkOutput("mr_din0", 32'(ramDinA), 0);
    checkOutput("mr_busy", 32'(fillBusyA), 0);
    rst = 1'b0;
    nextCycle();
    checkOutput("mr2_we",   32'(ramWeA), 0);
    checkOutput("mr2_busy", 32'(fillBusyA), 0);
    checkOutput("mr2_done", 32'(fillDoneA), 0);
    checkOutput("mr2_oob",  32'(errOobA), 0);

    // Blanking-only instance: 3 cycles high, 5 low, then high again
    startFill(20, 4, 'h321);
    blankPat = 9'b100000111;
    expAddr  = 20;
    for (int c = 0; c < 9; c++) begin
      blank = blankPat[c];
      #1 checkOutput("bl_hready", 32'(hReadyB), 32'(blankPat[c]));
      nextCycle();
      checkOutput("bl_we", 32'(ramWeB), 32'(blankPat[c]));
      if (blankPat[c]) begin
        checkOutput("bl_addr", 32'(ramAddrB), 32'(expAddr));
        checkOutput("bl_din",  32'(ramDinB), 'h321);
        expAddr++;
      end
      checkOutput("bl_done", 32'(fillDoneB), (c == 8) ? 1 : 0);
    end
    blank = 1'b0;
    checkOutput("bl_busy_end", 32'(fillBusyB), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
